// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the in-order WB stage and the late-returning MDU.
// Tracks MDU destinations in flight so decode can see hazards; the winning write is registered once.
module wb_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int STARVE_LIM = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_valid_i,
   input  logic            pipe_wen_i,
   input  logic [4:0]      pipe_rd_i,
   input  logic [XLEN-1:0] pipe_data_i,
   output logic            pipe_ready_o,
   input  logic            mdu_issue_i,
   input  logic [4:0]      mdu_issue_rd_i,
   input  logic            mdu_valid_i,
   input  logic [4:0]      mdu_rd_i,
   input  logic [XLEN-1:0] mdu_data_i,
   output logic            mdu_ready_o,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic            rf_wen_o,
   output logic [4:0]      rf_waddr_o,
   output logic [XLEN-1:0] rf_wdata_o
);

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   typedef enum logic {PIPE_PRI, MDU_FORCE} state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic [3:0]  cnt_inc;
   logic [31:0] sb_reg;
   logic [31:0] sb_next;
   logic        pipe_req;
   logic        pipe_grant;
   logic        mdu_grant;
   logic        mdu_lose;

   always_comb begin
      pipe_req   = pipe_valid_i & pipe_wen_i;
      pipe_grant = 1'b0;
      mdu_grant  = 1'b0;
      if (state_reg == MDU_FORCE) begin
         mdu_grant = mdu_valid_i;
      end else begin
         pipe_grant = pipe_req;
         mdu_grant  = mdu_valid_i & ~pipe_req;
      end
      mdu_lose     = mdu_valid_i & ~mdu_grant;
      cnt_inc      = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;
      pipe_ready_o = ~pipe_req | pipe_grant;
      mdu_ready_o  = mdu_grant;
   end

   // A new issue to the same index beats the clear of the returning result.
   assign sb_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_sb
         assign sb_next[gi] = (mdu_issue_i & (mdu_issue_rd_i == 5'(gi)))
                            | (sb_reg[gi] & ~(mdu_grant & (mdu_rd_i == 5'(gi))));
      end
   endgenerate

   assign rs1_busy_o = sb_reg[rs1_i];
   assign rs2_busy_o = sb_reg[rs2_i];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= PIPE_PRI;
         cnt_reg    <= 4'd0;
         sb_reg     <= 32'd0;
         rf_wen_o   <= 1'b0;
         rf_waddr_o <= 5'd0;
         rf_wdata_o <= '0;
      end else begin
         sb_reg <= sb_next;
         case (state_reg)
            PIPE_PRI: begin
               if (mdu_lose) begin
                  cnt_reg <= cnt_inc;
                  if (cnt_inc >= LIM)
                     state_reg <= MDU_FORCE;
               end else begin
                  cnt_reg <= 4'd0;
               end
            end
            default: begin
               // Force lasts one cycle: either the MDU is granted or it has withdrawn.
               cnt_reg   <= 4'd0;
               state_reg <= PIPE_PRI;
            end
         endcase

         if (pipe_grant) begin
            rf_wen_o   <= (pipe_rd_i != 5'd0);
            rf_waddr_o <= pipe_rd_i;
            rf_wdata_o <= pipe_data_i;
         end else if (mdu_grant) begin
            rf_wen_o   <= (mdu_rd_i != 5'd0);
            rf_waddr_o <= mdu_rd_i;
            rf_wdata_o <= mdu_data_i;
         end else begin
            rf_wen_o   <= 1'b0;
         end
      end
   end

   // Upstream must interlock on the busy outputs before retiring a pipe write.
   pipe_write_to_busy_rd : assert property (@(posedge clk) disable iff (rst)
      (pipe_grant && pipe_rd_i != 5'd0) |-> !sb_reg[pipe_rd_i]);

endmodule
